lab3_mem_line_memory_responder: RTL and testbench

// - Memory-side responder for the 16B line request/response interface issued by the lab3 blocking caches
// - Accepts one mem_req_16B_t at a time (READ, WRITE or INIT), applies it to a private line store and returns one mem_resp_16B_t after a fixed, configurable delay
// - Synthesizable backing store for cache unit tests and for the lab5 multi-bank composition; one instance per cache memory port

---
 rtl/lab3_mem_line_memory_responder_pkg.sv | 80 ++++++++
 rtl/lab3_mem_line_memory_responder_array.sv | 32 +++
 rtl/lab3_mem_line_memory_responder.sv | 145 ++++++++++++++
 tb/tb_lab3_mem_line_memory_responder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/lab3_mem_line_memory_responder_pkg.sv
// Shared types for the lab3 16B line memory responder: FSM states, request type codes,
// line request/response messages and byte-lane helpers.
package lab3_mem_line_memory_responder_pkg;

    typedef enum logic [1:0] {
        RSP_STATE_IDLE = 2'd0,
        RSP_STATE_WAIT = 2'd1,
        RSP_STATE_RESP = 2'd2
    } rsp_state_e;

    localparam logic [2:0] MEM_READ  = 3'd0;
    localparam logic [2:0] MEM_WRITE = 3'd1;
    localparam logic [2:0] MEM_INIT  = 3'd2;

    // Field layout matches the cache-side line message formats
    typedef struct packed {
        logic [2:0]   type_;
        logic [7:0]   opaque;
        logic [31:0]  addr;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_req_16B_t;

    typedef struct packed {
        logic [2:0]   type_;
        logic [7:0]   opaque;
        logic [1:0]   test;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_resp_16B_t;

    // len==0 selects the whole line; otherwise the run starting at off, clipped at byte 15
    function automatic logic [15:0] byte_mask(input logic [3:0] off, input logic [3:0] len);
        logic [15:0] m;
        m = 16'h0000;
        for (int b = 0; b < 16; b++) begin
            if (len == 4'd0) begin
                m[b] = 1'b1;
            end else if ((b >= int'(off)) && (b < int'(off) + int'(len))) begin
                m[b] = 1'b1;
            end else begin
                m[b] = 1'b0;
            end
        end
        return m;
    endfunction

    function automatic logic [127:0] place_bytes(input logic [127:0] data, input logic [3:0] off,
                                                 input logic [3:0] len);
        if (len == 4'd0) begin
            return data;
        end else begin
            return data << {off, 3'b000};
        end
    endfunction

    function automatic logic [127:0] extract_bytes(input logic [127:0] line, input logic [3:0] off,
                                                   input logic [3:0] len);
        logic [127:0] keep;
        keep = 128'h0;
        for (int b = 0; b < 16; b++) begin
            keep[b*8 +: 8] = (b < int'(len)) ? 8'hFF : 8'h00;
        end
        if (len == 4'd0) begin
            return line;
        end else begin
            return (line >> {off, 3'b000}) & keep;
        end
    endfunction

    function automatic logic [23:0] state_trace(input rsp_state_e s);
        case (s)
            RSP_STATE_IDLE: return "(I)";
            RSP_STATE_WAIT: return "(W)";
            RSP_STATE_RESP: return "(R)";
            default:        return "(?)";
        endcase
    endfunction

endpackage

// File: rtl/lab3_mem_line_memory_responder_array.sv
// Line store: p_num_lines x 128b, per-byte write enables, registered read, no reset so
// contents survive a responder reset.
module lab3_mem_line_memory_responder_array #(
    parameter int p_num_lines = 256,
    parameter int p_idx_w     = $clog2(p_num_lines)
) (
    input  logic               clk,
    input  logic               i_en,
    input  logic [p_idx_w-1:0] i_addr,
    input  logic [15:0]        i_wben,
    input  logic [127:0]       i_wdata,
    output logic [127:0]       o_rdata
);

    logic [127:0] r_mem [0:p_num_lines-1];
    logic [127:0] r_rdata;

    // Byte-masked write and read-before-write capture on an enabled access
    always_ff @(posedge clk) begin
        if (i_en) begin
            for (int b = 0; b < 16; b++) begin
                if (i_wben[b]) begin
                    r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/lab3_mem_line_memory_responder.sv
// Memory-side responder: one outstanding 16B line request, applied to a private store,
// answered after p_latency extra cycles.
module lab3_mem_line_memory_responder
    import lab3_mem_line_memory_responder_pkg::*;
#(
    parameter int p_num_lines = 256,
    parameter int p_latency   = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  mem_req_16B_t  memreq_msg,
    input  logic          memreq_val,
    output logic          memreq_rdy,
    output mem_resp_16B_t memresp_msg,
    output logic          memresp_val,
    input  logic          memresp_rdy
);

    localparam int         IDX_W = $clog2(p_num_lines);
    localparam logic [3:0] LAT   = 4'(p_latency);

    rsp_state_e   r_state;
    logic [3:0]   r_count;
    logic         r_req_rdy;
    logic         r_resp_val;
    logic [2:0]   r_type;
    logic [7:0]   r_opaque;
    logic [3:0]   r_len;
    logic [3:0]   r_off;
    logic         r_rd;

    logic             w_accept;
    logic             w_is_write;
    logic [IDX_W-1:0] w_idx;
    logic [15:0]      w_wben;
    logic [127:0]     w_wdata;
    logic [127:0]     w_line;
    logic             w_unused_addr;

    assign w_accept      = memreq_val & r_req_rdy;
    assign w_is_write    = (memreq_msg.type_ == MEM_WRITE) | (memreq_msg.type_ == MEM_INIT);
    assign w_idx         = memreq_msg.addr[4 +: IDX_W];
    // Upper address bits alias onto the same lines by design
    assign w_unused_addr = ^memreq_msg.addr;

    // Byte enables and lane-aligned write data for an accepted WRITE/INIT
    always_comb begin
        w_wben  = 16'h0000;
        w_wdata = place_bytes(memreq_msg.data, memreq_msg.addr[3:0], memreq_msg.len);
        if (w_accept && w_is_write) begin
            w_wben = byte_mask(memreq_msg.addr[3:0], memreq_msg.len);
        end else begin
            w_wben = 16'h0000;
        end
    end

    lab3_mem_line_memory_responder_array #(
        .p_num_lines (p_num_lines),
        .p_idx_w     (IDX_W)
    ) u_array (
        .clk     (clk),
        .i_en    (w_accept),
        .i_addr  (w_idx),
        .i_wben  (w_wben),
        .i_wdata (w_wdata),
        .o_rdata (w_line)
    );

    // Request/response FSM with latency counter and captured response header
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= RSP_STATE_IDLE;
            r_count    <= 4'd0;
            r_req_rdy  <= 1'b0;
            r_resp_val <= 1'b0;
            r_type     <= 3'd0;
            r_opaque   <= 8'd0;
            r_len      <= 4'd0;
            r_off      <= 4'd0;
            r_rd       <= 1'b0;
        end else begin
            case (r_state)
                RSP_STATE_IDLE: begin
                    if (w_accept) begin
                        r_type    <= memreq_msg.type_;
                        r_opaque  <= memreq_msg.opaque;
                        r_len     <= memreq_msg.len;
                        r_off     <= memreq_msg.addr[3:0];
                        r_rd      <= ~w_is_write;
                        r_req_rdy <= 1'b0;
                        if (LAT == 4'd0) begin
                            r_state    <= RSP_STATE_RESP;
                            r_resp_val <= 1'b1;
                        end else begin
                            r_state <= RSP_STATE_WAIT;
                            r_count <= LAT - 4'd1;
                        end
                    end else begin
                        r_req_rdy <= 1'b1;
                    end
                end
                RSP_STATE_WAIT: begin
                    if (r_count == 4'd0) begin
                        r_state    <= RSP_STATE_RESP;
                        r_resp_val <= 1'b1;
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end
                RSP_STATE_RESP: begin
                    if (memresp_rdy) begin
                        r_state    <= RSP_STATE_IDLE;
                        r_resp_val <= 1'b0;
                        r_req_rdy  <= 1'b1;
                    end else begin
                        r_resp_val <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= RSP_STATE_IDLE;
                    r_req_rdy  <= 1'b0;
                    r_resp_val <= 1'b0;
                end
            endcase
        end
    end

    // The store's read register holds the line until the next accepted request
    always_comb begin
        memresp_msg.type_  = r_type;
        memresp_msg.opaque = r_opaque;
        memresp_msg.test   = 2'b00;
        memresp_msg.len    = r_len;
        memresp_msg.data   = 128'h0;
        if (r_rd) begin
            memresp_msg.data = extract_bytes(w_line, r_off, r_len);
        end else begin
            memresp_msg.data = 128'h0;
        end
    end

    assign memreq_rdy  = r_req_rdy;
    assign memresp_val = r_resp_val;

endmodule

// File: tb/tb_lab3_mem_line_memory_responder.sv
// Randomized scoreboard bench for the line memory responder (p_latency=3, 256 lines).
module tb_lab3_mem_line_memory_responder;
    import lab3_mem_line_memory_responder_pkg::*;

    localparam int NL  = 256;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    mem_req_16B_t  memreq_msg;
    logic          memreq_val;
    logic          memreq_rdy;
    mem_resp_16B_t memresp_msg;
    logic          memresp_val;
    logic          memresp_rdy = 1'b0;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int cyc      = 0;
    int n_resp   = 0;

    typedef struct {
        logic [2:0]   typ;
        logic [7:0]   opq;
        logic [3:0]   len;
        logic [127:0] data;
        int           acc_cyc;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] ref_mem [0:NL-1][0:15];

    lab3_mem_line_memory_responder #(
        .p_num_lines (NL),
        .p_latency   (LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .memreq_msg  (memreq_msg),
        .memreq_val  (memreq_val),
        .memreq_rdy  (memreq_rdy),
        .memresp_msg (memresp_msg),
        .memresp_val (memresp_val),
        .memresp_rdy (memresp_rdy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
        chk_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    // Reference: the store as an array of byte lists, updated in request order
    function automatic exp_t model(input logic [2:0] typ, input logic [7:0] opq, input logic [31:0] addr,
                                   input logic [3:0] len, input logic [127:0] data);
        exp_t e;
        int idx;
        int off;
        int n;
        int pos;
        idx = int'((addr >> 4) % NL);
        off = int'(addr % 16);
        n = (len == 4'd0) ? 16 : int'(len);
        e.typ = typ; e.opq = opq; e.len = len; e.data = 128'h0; e.acc_cyc = 0;
        for (int k = 0; k < n; k++) begin
            pos = (len == 4'd0) ? k : off + k;
            if (pos < 16) begin
                if (typ == MEM_WRITE || typ == MEM_INIT) ref_mem[idx][pos] = data[k*8 +: 8];
                else e.data[k*8 +: 8] = ref_mem[idx][pos];
            end
        end
        return e;
    endfunction

    task automatic send(input logic [2:0] typ, input logic [7:0] opq, input logic [31:0] addr,
                        input logic [3:0] len, input logic [127:0] data);
        exp_t e;
        int waited;
        waited = 0;
        memreq_msg.type_  = typ;
        memreq_msg.opaque = opq;
        memreq_msg.addr   = addr;
        memreq_msg.len    = len;
        memreq_msg.data   = data;
        memreq_val = 1'b1;
        while (!memreq_rdy && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!memreq_rdy) begin
            check("req_accept_timeout", 160'(memreq_rdy), 160'(1));
        end else begin
            e = model(typ, opq, addr, len, data);
            e.acc_cyc = cyc;
            exp_q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        memreq_val = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        check("drain_queue", 160'(exp_q.size()), 160'(0));
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: drives memresp_rdy, checks latency, stability and response contents
    mem_resp_16B_t held_msg;
    logic          prev_val = 1'b0;
    logic          prev_hs = 1'b0;
    int            stall = 0;
    always @(negedge clk) begin : mon
        exp_t e;
        if (reset) begin
            prev_val = 1'b0;
            prev_hs = 1'b0;
            stall = 0;
            memresp_rdy = 1'b0;
        end else begin
            if (prev_hs) check("val_drop_after_hs", 160'(memresp_val), 160'(0));
            prev_hs = 1'b0;
            if (memresp_val) begin
                check("req_rdy_low_in_resp", 160'(memreq_rdy), 160'(0));
                if (!prev_val) begin
                    held_msg = memresp_msg;
                    stall = (n_resp == 0) ? 5 : int'($urandom_range(0, 3));
                    if (exp_q.size() == 0) check("unexpected_resp", 160'(memresp_val), 160'(0));
                    else check("latency", 160'(cyc - exp_q[0].acc_cyc), 160'(LAT + 1));
                end else begin
                    check("resp_stable", 160'(memresp_msg), 160'(held_msg));
                end
                if (stall > 0) begin
                    memresp_rdy = 1'b0;
                    stall--;
                end else begin
                    memresp_rdy = 1'b1;
                    prev_hs = 1'b1;
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("resp_type", 160'(memresp_msg.type_), 160'(e.typ));
                        check("resp_opaque", 160'(memresp_msg.opaque), 160'(e.opq));
                        check("resp_test", 160'(memresp_msg.test), 160'(0));
                        check("resp_len", 160'(memresp_msg.len), 160'(e.len));
                        check("resp_data", 160'(memresp_msg.data), 160'(e.data));
                        n_resp++;
                    end
                end
            end else begin
                memresp_rdy = 1'($urandom_range(0, 1));
            end
            prev_val = memresp_val;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks, required completion", chk_cnt);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [2:0]  typ;
        logic [31:0] addr;
        memreq_val = 1'b0;
        memreq_msg = '0;
        repeat (3) @(negedge clk);
        check("rst_req_rdy", 160'(memreq_rdy), 160'(0));
        check("rst_resp_val", 160'(memresp_val), 160'(0));
        check("rst_resp_msg", 160'(memresp_msg), 160'(0));
        reset = 1'b0;

        send(MEM_INIT, 8'h11, 32'h0000_1000, 4'd0, 128'h0f0e0d0c0b0a09080706050403020100);
        send(MEM_READ, 8'h22, 32'h0000_1000, 4'd0, 128'h0);
        for (int i = 1; i < 8; i++) send(MEM_INIT, 8'(i), 32'(i * 16), 4'd0, rand128());
        send(MEM_WRITE, 8'h33, 32'h0000_1004, 4'd4, 128'hdeadbeef);
        send(MEM_READ, 8'h44, 32'h0000_1000, 4'd0, 128'h0);
        send(MEM_WRITE, 8'h55, 32'h0000_0010, 4'd0, rand128());
        send(MEM_READ, 8'h66, 32'h0000_1010, 4'd0, 128'h0);

        for (int i = 0; i < 80; i++) begin
            typ  = 3'($urandom_range(0, 4));
            addr = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 7) << 4) | 32'($urandom_range(0, 15));
            send(typ, 8'($urandom), addr, 4'($urandom_range(0, 15)), rand128());
        end
        drain();

        // Reset while the WRITE waits out its latency: response is dropped, data stays written
        send(MEM_WRITE, 8'h77, 32'h0000_0020, 4'd0, rand128());
        reset = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        check("rst2_req_rdy", 160'(memreq_rdy), 160'(0));
        check("rst2_resp_val", 160'(memresp_val), 160'(0));
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_resp_after_rst", 160'(memresp_val), 160'(0));
        end
        send(MEM_READ, 8'h88, 32'h0000_0020, 4'd0, 128'h0);
        drain();
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
